// File: rtl/clb_cfg_pkg.sv
// Shared types and helpers for the CLB configuration loader.
// Holds the loader state encoding, the default LUT geometry and the cen one-hot decode.
package clb_cfg_pkg;

   localparam int DEF_ADDR_BITS = 4;
   localparam int DEF_MEM_SIZE  = 2 ** DEF_ADDR_BITS;
   localparam int MAX_LUTS      = 32;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      COMMIT,
      DONE
   } cfg_state_t;

   // Callers size-cast the result down to their own LUT count.
   function automatic logic [MAX_LUTS-1:0] lut_onehot(input logic [31:0] idx);
      logic [MAX_LUTS-1:0] oh;
      oh = '0;
      for (int i = 0; i < MAX_LUTS; i++) begin
         oh[i] = (idx == 32'(i));
      end
      return oh;
   endfunction

endpackage

// File: rtl/cfg_shift_reg.sv
// Serial-in / parallel-out frame assembler: bits enter at the MSB and shift right.
// frame is the look-ahead value including bit_in, so the last bit needs no storage.
module cfg_shift_reg
   import clb_cfg_pkg::*;
#(
   parameter int WIDTH = DEF_MEM_SIZE
) (
   input  logic             cclk,
   input  logic             clr,
   input  logic             shift_en,
   input  logic             bit_in,
   output logic [WIDTH-1:0] frame
);

   logic [WIDTH-1:1] q;

   assign frame = {bit_in, q};

   // NOTE: non-blocking assignment lets every stage sample the pre-edge value, so the shift has no ordering race.
   // NOTE: the partial frame is cleared explicitly so a discarded frame can never leak into the next one.
   always_ff @(posedge cclk) begin
      if (clr) begin
         q <= '0;
      end else if (shift_en) begin
         q <= frame[WIDTH-1:1];
      end
   end

endmodule

// File: rtl/lut_config_loader.sv
// Serial configuration loader for a group of bit-writable LUT blocks.
// Assembles one frame per LUT and pulses a one-hot cen while the shared config_in is stable.
module lut_config_loader
   import clb_cfg_pkg::*;
#(
   parameter int ADDR_BITS = DEF_ADDR_BITS,
   parameter int MEM_SIZE  = 2 ** ADDR_BITS,
   parameter int NUM_LUTS  = 4,
   parameter int SEL_BITS  = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1
) (
   input  logic                cclk,
   input  logic                rst,
   input  logic                start,
   input  logic                bit_in,
   input  logic                bit_valid,
   output logic                bit_ready,
   output logic [MEM_SIZE-1:0] config_in,
   output logic [NUM_LUTS-1:0] cen,
   output logic [SEL_BITS-1:0] lut_idx,
   output logic                busy,
   output logic                done
);

   localparam int                CNT_BITS = $clog2(MEM_SIZE) + 1;
   localparam logic [CNT_BITS-1:0] LAST_BIT = CNT_BITS'(MEM_SIZE - 1);
   localparam logic [SEL_BITS-1:0] LAST_LUT = SEL_BITS'(NUM_LUTS - 1);

   cfg_state_t          state_q, state_d;
   logic [CNT_BITS-1:0] bit_cnt_q, bit_cnt_d;
   logic [SEL_BITS-1:0] lut_idx_d;
   logic [MEM_SIZE-1:0] config_in_d;
   logic [NUM_LUTS-1:0] cen_d;
   logic                bit_ready_d, busy_d, done_d;
   logic                accept, sr_clr;
   logic [MEM_SIZE-1:0] sr_frame;

   assign accept = (state_q == LOAD) && bit_ready && bit_valid;

   cfg_shift_reg #(
      .WIDTH (MEM_SIZE)
   ) u_shift (
      .cclk     (cclk),
      .clr      (rst | sr_clr),
      .shift_en (accept),
      .bit_in   (bit_in),
      .frame    (sr_frame)
   );

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      lut_idx_d   = lut_idx;
      config_in_d = config_in;
      cen_d       = '0;
      bit_ready_d = bit_ready;
      busy_d      = busy;
      done_d      = done;
      sr_clr      = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d     = LOAD;
               busy_d      = 1'b1;
               bit_ready_d = 1'b1;
               lut_idx_d   = '0;
               bit_cnt_d   = '0;
               done_d      = 1'b0;
               sr_clr      = 1'b1;
            end
         end
         LOAD: begin
            if (accept) begin
               bit_cnt_d = bit_cnt_q + CNT_BITS'(1);
               // Last bit: publish the frame and strobe cen in the same edge bit_ready drops.
               if (bit_cnt_q == LAST_BIT) begin
                  config_in_d = sr_frame;
                  cen_d       = NUM_LUTS'(lut_onehot(32'(lut_idx)));
                  bit_ready_d = 1'b0;
                  state_d     = COMMIT;
               end
            end
         end
         COMMIT: begin
            sr_clr = 1'b1;
            if (lut_idx == LAST_LUT) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               lut_idx_d   = lut_idx + SEL_BITS'(1);
               bit_cnt_d   = '0;
               bit_ready_d = 1'b1;
               state_d     = LOAD;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge cclk) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         lut_idx   <= '0;
         config_in <= '0;
         cen       <= '0;
         bit_ready <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         lut_idx   <= lut_idx_d;
         config_in <= config_in_d;
         cen       <= cen_d;
         bit_ready <= bit_ready_d;
         busy      <= busy_d;
         done      <= done_d;
      end
   end

endmodule

// File: tb/tb_lut_config_loader.sv
// Scoreboarded bench for lut_config_loader: a single-LUT and a four-LUT instance share the bit stream.
// Expected commits are queued at stimulus time and checked by a monitor whenever cen fires.
module tb_lut_config_loader;

   typedef struct {
      logic [3:0]  cen;
      logic [15:0] cfg;
   } exp_t;

   logic        cclk = 1'b0;
   logic        rst, start1, start4, bit_in, bit_valid;

   logic        rdy1, busy1, done1;
   logic [15:0] cfg1;
   logic [0:0]  cen1, idx1;

   logic        rdy4, busy4, done4;
   logic [15:0] cfg4;
   logic [3:0]  cen4;
   logic [1:0]  idx4;

   exp_t q1[$];
   exp_t q4[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   start_cyc = 0;
   int   cen1_cyc = -1;
   int   acc1 = 0;
   int   acc4 = 0;

   always #5 cclk = ~cclk;

   lut_config_loader #(.ADDR_BITS(4), .NUM_LUTS(1)) u1 (
      .cclk(cclk), .rst(rst), .start(start1), .bit_in(bit_in), .bit_valid(bit_valid),
      .bit_ready(rdy1), .config_in(cfg1), .cen(cen1), .lut_idx(idx1), .busy(busy1), .done(done1)
   );

   lut_config_loader #(.ADDR_BITS(4), .NUM_LUTS(4)) u4 (
      .cclk(cclk), .rst(rst), .start(start4), .bit_in(bit_in), .bit_valid(bit_valid),
      .bit_ready(rdy4), .config_in(cfg4), .cen(cen4), .lut_idx(idx4), .busy(busy4), .done(done4)
   );

   always @(posedge cclk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: counts accepts and pops one expected commit per cen pulse.
   always @(negedge cclk) begin
      exp_t e;
      if (bit_valid && rdy1) acc1++;
      if (bit_valid && rdy4) acc4++;
      if (cen4 != 4'b0000) begin
         if (q4.size() == 0) begin
            check("u4_unexpected_cen", 32'(cen4), 0);
         end else begin
            e = q4.pop_front();
            check("u4_cen", 32'(cen4), 32'(e.cen));
            check("u4_config_in", 32'(cfg4), 32'(e.cfg));
         end
      end
      if (cen1 != 1'b0) begin
         cen1_cyc = cyc;
         if (q1.size() == 0) begin
            check("u1_unexpected_cen", 32'(cen1), 0);
         end else begin
            e = q1.pop_front();
            check("u1_cen", 32'(cen1), 32'(e.cen));
            check("u1_config_in", 32'(cfg1), 32'(e.cfg));
         end
      end
   end

   task automatic tick();
      @(posedge cclk);
      #1;
   endtask

   task automatic push4(input logic [3:0] c, input logic [15:0] f);
      exp_t e;
      e.cen = c;
      e.cfg = f;
      q4.push_back(e);
   endtask

   task automatic push1(input logic [15:0] f);
      exp_t e;
      e.cen = 4'b0001;
      e.cfg = f;
      q1.push_back(e);
   endtask

   task automatic pulse_start(input bit sel);
      if (sel) start4 = 1'b1;
      else     start1 = 1'b1;
      start_cyc = cyc;
      tick();
      start1 = 1'b0;
      start4 = 1'b0;
   endtask

   // Sends bits data[from +: n] LSB first; pat[i%4] gates bit_valid on successive cycles.
   task automatic send_bits(input bit sel, input logic [15:0] data, input int from, input int n,
                            input logic [3:0] pat, output bit rdy_all);
      int k;
      int p;
      int guard;
      bit rdy;
      bit acc;
      k = from;
      p = 0;
      guard = 0;
      rdy_all = 1'b1;
      while (k < from + n) begin
         bit_in    = data[k];
         bit_valid = pat[p % 4];
         p++;
         @(negedge cclk);
         rdy = sel ? rdy4 : rdy1;
         acc = bit_valid && rdy;
         if (!rdy) rdy_all = 1'b0;
         tick();
         if (acc) k++;
         guard++;
         if (guard > 200) begin
            check("send_timeout", 0, 1);
            break;
         end
      end
      bit_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit r;
      int a;
      rst = 1'b1; start1 = 1'b0; start4 = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("rst_busy", 32'(busy4), 0);
      check("rst_done", 32'(done4), 0);
      check("rst_cen", 32'(cen4), 0);
      check("rst_bit_ready", 32'(rdy4), 0);
      check("rst_lut_idx", 32'(idx4), 0);
      check("rst_config_in", 32'(cfg4), 0);

      // Single frame on the one-LUT instance at full rate; u4 stays idle.
      push1(16'hA5C3);
      pulse_start(1'b0);
      send_bits(1'b0, 16'hA5C3, 0, 16, 4'b1111, r);
      tick();
      check("u1_cen_latency", 32'(cen1_cyc - start_cyc), 17);
      check("u1_done", 32'(done1), 1);
      check("u1_busy", 32'(busy1), 0);
      check("u1_cen_low", 32'(cen1), 0);
      check("idle_bit_ready", 32'(rdy4), 0);
      check("idle_config_in", 32'(cfg4), 0);
      check("idle_accepts", 32'(acc4), 0);

      // Backpressure frame on LUT 0 of the four-LUT instance.
      push4(4'b0001, 16'hA5C3);
      pulse_start(1'b1);
      a = acc4;
      send_bits(1'b1, 16'hA5C3, 0, 16, 4'b1001, r);
      check("bp_ready_high", 32'(r), 1);
      tick();
      check("bp_accepts", 32'(acc4 - a), 16);
      check("bp_lut_idx", 32'(idx4), 1);
      check("bp_ready_next", 32'(rdy4), 1);
      check("done_u1_bits_ignored", 32'(acc1), 16);
      check("done_u1_config_held", 32'(cfg1), 32'h0000A5C3);

      // Reset after 7 bits of LUT 1.
      send_bits(1'b1, 16'hFFFF, 0, 7, 4'b1111, r);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_cen", 32'(cen4), 0);
      check("abort_busy", 32'(busy4), 0);
      check("abort_lut_idx", 32'(idx4), 0);
      check("abort_bit_ready", 32'(rdy4), 0);
      check("abort_config_in", 32'(cfg4), 0);
      check("abort_u1_done", 32'(done1), 0);
      repeat (3) tick();

      // Full sequence, with a start pulse in the middle of LUT 1.
      push4(4'b0001, 16'h0001);
      push4(4'b0010, 16'h8000);
      push4(4'b0100, 16'hFFFF);
      push4(4'b1000, 16'h1234);
      pulse_start(1'b1);
      check("restart_lut_idx", 32'(idx4), 0);
      send_bits(1'b1, 16'h0001, 0, 16, 4'b1111, r);
      send_bits(1'b1, 16'h8000, 0, 5, 4'b1111, r);
      a = acc4;
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      check("busy_start_lut_idx", 32'(idx4), 1);
      check("busy_start_busy", 32'(busy4), 1);
      check("busy_start_accepts", 32'(acc4 - a), 0);
      send_bits(1'b1, 16'h8000, 5, 11, 4'b1111, r);
      send_bits(1'b1, 16'hFFFF, 0, 16, 4'b1111, r);
      send_bits(1'b1, 16'h1234, 0, 16, 4'b1111, r);
      tick();
      check("seq_done", 32'(done4), 1);
      check("seq_busy", 32'(busy4), 0);
      check("seq_lut_idx", 32'(idx4), 3);

      // bit_valid in DONE is ignored.
      bit_valid = 1'b1;
      bit_in = 1'b1;
      a = acc4;
      repeat (4) begin
         tick();
         check("done_bit_ready", 32'(rdy4), 0);
      end
      bit_valid = 1'b0;
      check("done_accepts", 32'(acc4 - a), 0);
      check("done_config_held", 32'(cfg4), 32'h00001234);

      // start in DONE restarts from LUT 0.
      push4(4'b0001, 16'h0F0F);
      pulse_start(1'b1);
      check("redo_done", 32'(done4), 0);
      check("redo_busy", 32'(busy4), 1);
      check("redo_lut_idx", 32'(idx4), 0);
      check("redo_bit_ready", 32'(rdy4), 1);
      send_bits(1'b1, 16'h0F0F, 0, 16, 4'b1111, r);
      tick();
      check("redo_next_lut", 32'(idx4), 1);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      check("u4_queue_drained", 32'(q4.size()), 0);
      check("u1_queue_drained", 32'(q1.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
